// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 win checker.
// Board geometry, cell codes, probe directions and checker FSM states.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  // Signed probe width: anchor + (WIN_LEN-1) must never overflow into the sign bit.
  localparam int PROBE_W = $clog2(((ROWS > COLS) ? ROWS : COLS) + WIN_LEN) + 1;

  typedef logic [1:0] cell_t;
  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P0    = 2'b01;
  localparam cell_t CELL_P1    = 2'b10;

  typedef cell_t [COLS-1:0] row_t;
  typedef row_t  [ROWS-1:0] board_t;

  typedef enum logic [1:0] {DIR_E, DIR_S, DIR_SE, DIR_SW} dir_t;

  typedef enum logic [1:0] {CHK_IDLE, CHK_SCAN, CHK_REPORT} chk_state_t;

  function automatic cell_t target_code(input logic player_turn);
    return player_turn ? CELL_P1 : CELL_P0;
  endfunction

  function automatic logic top_row_full(input board_t b);
    logic full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (b[0][c] == CELL_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/connect4_line_probe.sv
// Combinational line probe: does a WIN_LEN run of the target code start at the
// anchor and extend in the given direction, staying entirely on the board?
module connect4_line_probe
  import connect4_pkg::*;
(
  input  board_t           i_board,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  input  dir_t             i_dir,
  input  cell_t            i_target,
  output logic             o_hit
);

  localparam logic signed [PROBE_W-1:0] ROWS_S = PROBE_W'(ROWS);
  localparam logic signed [PROBE_W-1:0] COLS_S = PROBE_W'(COLS);

  logic signed [PROBE_W-1:0] w_dr;
  logic signed [PROBE_W-1:0] w_dc;
  logic signed [PROBE_W-1:0] w_r;
  logic signed [PROBE_W-1:0] w_c;

  always_comb begin
    w_dr = '0;
    w_dc = '0;
    case (i_dir)
      DIR_E:  w_dc = PROBE_W'(1);
      DIR_S:  w_dr = PROBE_W'(1);
      DIR_SE: begin w_dr = PROBE_W'(1); w_dc = PROBE_W'(1); end
      DIR_SW: begin w_dr = PROBE_W'(1); w_dc = '1; end  // column step of -1
      default: ;
    endcase
  end

  // NOTE: w_r/w_c are walked with blocking assignments so each loop iteration
  // sees the coordinate produced by the previous one; this is pure combinational logic.
  always_comb begin
    o_hit = 1'b1;
    w_r   = PROBE_W'(i_row);
    w_c   = PROBE_W'(i_col);
    for (int i = 0; i < WIN_LEN; i++) begin
      if (w_r[PROBE_W-1] || w_c[PROBE_W-1] || (w_r >= ROWS_S) || (w_c >= COLS_S)) begin
        o_hit = 1'b0;
      end else if (i_board[w_r[ROW_W-1:0]][w_c[COL_W-1:0]] != i_target) begin
        o_hit = 1'b0;
      end
      w_r = w_r + w_dr;
      w_c = w_c + w_dc;
    end
  end

endmodule

// File: rtl/connect4_win_checker.sv
// Sequential Connect-4 verdict engine: snapshots the board on start and scans one
// anchor per clock. Optional macro CONNECT4_WIN_LOCATE_EN adds win location outputs.
module connect4_win_checker
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_player_turn,
  input  board_t           i_board,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_win_detected,
  output logic             o_board_full
`ifdef CONNECT4_WIN_LOCATE_EN
  ,
  output logic [ROW_W-1:0] o_win_row,
  output logic [COL_W-1:0] o_win_col,
  output logic [1:0]       o_win_dir
`endif
);

  chk_state_t       r_state;
  chk_state_t       w_next;
  board_t           r_snap;
  cell_t            r_target;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_win;
  logic             r_full;
  logic [3:0]       w_hit;
  logic             w_any_hit;
  logic             w_last;

  connect4_line_probe u_probe_e (
    .i_board(r_snap), .i_row(r_row), .i_col(r_col), .i_dir(DIR_E),
    .i_target(r_target), .o_hit(w_hit[DIR_E])
  );
  connect4_line_probe u_probe_s (
    .i_board(r_snap), .i_row(r_row), .i_col(r_col), .i_dir(DIR_S),
    .i_target(r_target), .o_hit(w_hit[DIR_S])
  );
  connect4_line_probe u_probe_se (
    .i_board(r_snap), .i_row(r_row), .i_col(r_col), .i_dir(DIR_SE),
    .i_target(r_target), .o_hit(w_hit[DIR_SE])
  );
  connect4_line_probe u_probe_sw (
    .i_board(r_snap), .i_row(r_row), .i_col(r_col), .i_dir(DIR_SW),
    .i_target(r_target), .o_hit(w_hit[DIR_SW])
  );

  assign w_any_hit = |w_hit;
  assign w_last    = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CHK_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CHK_IDLE:   if (i_start) w_next = CHK_SCAN;
      CHK_SCAN:   if (w_any_hit || w_last) w_next = CHK_REPORT;
      CHK_REPORT: w_next = CHK_IDLE;
      default:    w_next = CHK_IDLE;
    endcase
  end

  // NOTE: the snapshot is plain flops, not a RAM, so it is reset along with
  // the rest of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap   <= '0;
      r_target <= CELL_EMPTY;
      r_row    <= '0;
      r_col    <= '0;
      r_win    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        CHK_IDLE: begin
          if (i_start) begin
            r_snap   <= i_board;
            r_target <= target_code(i_player_turn);
            r_row    <= '0;
            r_col    <= '0;
            r_win    <= 1'b0;
            r_full   <= 1'b0;
          end
        end
        CHK_SCAN: begin
          if (w_any_hit) begin
            r_win  <= 1'b1;
            r_full <= 1'b0;
          end else if (w_last) begin
            r_full <= top_row_full(r_snap);
          end else if (r_col == COL_W'(COLS - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state == CHK_SCAN);
  assign o_done         = (r_state == CHK_REPORT);
  assign o_win_detected = r_win;
  assign o_board_full   = r_full;

`ifdef CONNECT4_WIN_LOCATE_EN
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  dir_t             r_win_dir;
  dir_t             w_hit_dir;

  // Direction priority when several lines hit the same anchor: E > S > SE > SW.
  always_comb begin
    if (w_hit[DIR_E])       w_hit_dir = DIR_E;
    else if (w_hit[DIR_S])  w_hit_dir = DIR_S;
    else if (w_hit[DIR_SE]) w_hit_dir = DIR_SE;
    else                    w_hit_dir = DIR_SW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= DIR_E;
    end else if (r_state == CHK_IDLE && i_start) begin
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= DIR_E;
    end else if (r_state == CHK_SCAN && w_any_hit) begin
      r_win_row <= r_row;
      r_win_col <= r_col;
      r_win_dir <= w_hit_dir;
    end
  end

  assign o_win_row = r_win_row;
  assign o_win_col = r_win_col;
  assign o_win_dir = r_win_dir;
`endif

endmodule

// File: tb/tb_connect4_win_checker.sv
// Scoreboard bench for connect4_win_checker: the driver queues expected verdicts,
// the monitor pops one on every done pulse and compares latency and results.
module tb_connect4_win_checker;
  import connect4_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   i_start;
  logic   i_player_turn;
  board_t i_board;
  logic   o_busy;
  logic   o_done;
  logic   o_win_detected;
  logic   o_board_full;
`ifdef CONNECT4_WIN_LOCATE_EN
  logic [ROW_W-1:0] o_win_row;
  logic [COL_W-1:0] o_win_col;
  logic [1:0]       o_win_dir;
`endif

  connect4_win_checker dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_player_turn(i_player_turn),
    .i_board(i_board),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_win_detected(o_win_detected),
    .o_board_full(o_board_full)
`ifdef CONNECT4_WIN_LOCATE_EN
    ,
    .o_win_row(o_win_row),
    .o_win_col(o_win_col),
    .o_win_dir(o_win_dir)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    lat;
    logic  win;
    logic  full;
    int    wr;
    int    wc;
    int    wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every done pulse consumes one expected verdict.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, ".latency"}, cyc - start_cyc + 1, mon_e.lat);
        check({mon_e.name, ".win"}, o_win_detected, mon_e.win);
        check({mon_e.name, ".full"}, o_board_full, mon_e.full);
        check({mon_e.name, ".busy_at_done"}, o_busy, 0);
`ifdef CONNECT4_WIN_LOCATE_EN
        if (mon_e.win) begin
          check({mon_e.name, ".win_row"}, o_win_row, mon_e.wr);
          check({mon_e.name, ".win_col"}, o_win_col, mon_e.wc);
          check({mon_e.name, ".win_dir"}, o_win_dir, mon_e.wd);
        end
`endif
      end
    end
  end

  task automatic push_exp(input string name, input int k, input logic full,
                          input int wr, input int wc, input int wd);
    exp_t e;
    e.name = name;
    e.lat  = (k < 0) ? ROWS * COLS + 1 : k + 2;
    e.win  = (k >= 0);
    e.full = full;
    e.wr   = wr;
    e.wc   = wc;
    e.wd   = wd;
    exp_q.push_back(e);
  endtask

  task automatic issue_start(input board_t b, input logic pl);
    @(negedge clk);
    i_board       = b;
    i_player_turn = pl;
    i_start       = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got no done in 100 cycles, expected done", name);
    end
  endtask

  task automatic run(input string name, input board_t b, input logic pl, input int k,
                     input logic full, input int wr, input int wc, input int wd);
    int d0 = done_cnt;
    push_exp(name, k, full, wr, wc, wd);
    issue_start(b, pl);
    wait_done(name, d0);
    @(negedge clk);
    check({name, ".done_one_cycle"}, o_done, 0);
    repeat (2) @(negedge clk);
    check({name, ".win_held"}, o_win_detected, (k >= 0));
    check({name, ".full_held"}, o_board_full, full);
  endtask

  board_t b_horiz, b_vert, b_sw, b_se, b_wrap, b_draw, b_bad;
  int     d0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b_horiz = '0;
    for (int c = 0; c < 4; c++) b_horiz[5][c] = CELL_P0;
    b_vert = '0;
    for (int r = 2; r < 6; r++) b_vert[r][6] = CELL_P1;
    b_sw = '0;
    for (int i = 0; i < 4; i++) b_sw[2+i][3-i] = CELL_P0;
    b_se = '0;
    for (int i = 0; i < 4; i++) b_se[i][i] = CELL_P1;
    b_wrap = '0;
    for (int c = 4; c < 7; c++) b_wrap[0][c] = CELL_P0;
    b_wrap[1][0] = CELL_P0;
    b_bad = '0;
    for (int c = 0; c < 4; c++) b_bad[5][c] = 2'b11;
    // Runs never exceed two in any direction with this colouring.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b_draw[r][c] = (((r / 2) + c) % 2 == 0) ? CELL_P0 : CELL_P1;

    rst_n         = 1'b0;
    i_start       = 1'b0;
    i_player_turn = 1'b0;
    i_board       = '0;
    #1;
    check("reset.busy", o_busy, 0);
    check("reset.done", o_done, 0);
    check("reset.win", o_win_detected, 0);
    check("reset.full", o_board_full, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("horizontal", b_horiz, 1'b0, 35, 1'b0, 5, 0, 0);
    run("vertical_p1", b_vert, 1'b1, 20, 1'b0, 2, 6, 1);
    run("vertical_p0", b_vert, 1'b0, -1, 1'b0, 0, 0, 0);
    run("diag_sw", b_sw, 1'b0, 17, 1'b0, 2, 3, 3);
    run("diag_se", b_se, 1'b1, 0, 1'b0, 0, 0, 2);
    run("no_wrap", b_wrap, 1'b0, -1, 1'b0, 0, 0, 0);
    run("invalid_code", b_bad, 1'b0, -1, 1'b0, 0, 0, 0);
    run("draw_p0", b_draw, 1'b0, -1, 1'b1, 0, 0, 0);
    run("draw_p1", b_draw, 1'b1, -1, 1'b1, 0, 0, 0);

    // Board change and re-start mid-scan: the verdict follows the snapshot.
    d0 = done_cnt;
    push_exp("snapshot", 35, 1'b0, 5, 0, 0);
    issue_start(b_horiz, 1'b0);
    repeat (4) @(negedge clk);
    check("snapshot.busy_mid_scan", o_busy, 1);
    i_board       = b_draw;
    i_player_turn = 1'b1;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("snapshot", d0);
    repeat (50) @(negedge clk);
    check("snapshot.single_done", done_cnt - d0, 1);

    // Reset mid-scan: outputs drop at once and no done pulse follows.
    run("prewin", b_horiz, 1'b0, 35, 1'b0, 5, 0, 0);
    d0 = done_cnt;
    issue_start(b_vert, 1'b0);
    repeat (9) @(negedge clk);
    check("abort.busy_before", o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.busy", o_busy, 0);
    check("abort.done", o_done, 0);
    check("abort.win", o_win_detected, 0);
    check("abort.full", o_board_full, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort.no_done", done_cnt - d0, 0);
    check("abort.idle", o_busy, 0);

    run("after_abort", b_sw, 1'b0, 17, 1'b0, 2, 3, 3);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
